// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: camera-style raster test-pattern source for the SDRAM write port.
// Emits line ramp, frame ramp, RGB565 colour bars or a checkerboard. Start and stop
// take effect only at frame boundaries.
// Optional build macro: CAM_PATGEN_FRAME_TAG_EN replaces the first active pixel of
// each frame with the completed-frame count.
module cam_pattern_gen #(
  parameter int H_TOTAL  = 1024,
  parameter int V_TOTAL  = 512,
  parameter int H_START  = 1,
  parameter int H_ACTIVE = 400,
  parameter int V_START  = 1,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 16
) (
  input  logic              cam0_pclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_start,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int BW  = H_ACTIVE / 8;
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [1:0]      mode_q;
  logic [DATA_W-1:0] ramp_q;
  logic [BCW-1:0]  bar_cnt_q;
  logic [3:0]      bar_idx_q;

  logic [31:0]     h_i;
  logic [31:0]     v_i;
  logic            line_end;
  logic            frame_end;
  logic            pix_act;
  logic            first_pix;
  logic [HW-1:0]   x;
  logic [VW-1:0]   y;
  logic [BCW-1:0]  bar_cnt_eff;
  logic [3:0]      bar_idx_eff;
  logic [DATA_W-1:0] pix;

  // RGB565 colour for each of the eight bars, left to right
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  assign h_i       = 32'(h_cnt);
  assign v_i       = 32'(v_cnt);
  assign line_end  = (h_cnt == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (v_cnt == VW'(V_TOTAL - 1));
  assign pix_act   = (state != IDLE)
                     && (h_i >= 32'(H_START)) && (h_i < 32'(H_START + H_ACTIVE))
                     && (v_i >= 32'(V_START)) && (v_i < 32'(V_START + V_ACTIVE));
  assign first_pix = (h_i == 32'(H_START)) && (v_i == 32'(V_START));
  assign x         = h_cnt - HW'(H_START);
  assign y         = v_cnt - VW'(V_START);

  // Bar position restarts at the first pixel of every line
  assign bar_cnt_eff = (x == '0) ? '0 : bar_cnt_q;
  assign bar_idx_eff = (x == '0) ? '0 : bar_idx_q;

  // Pattern value for the counter state currently being processed
  always_comb begin
    pix = '0;
    case (mode_q)
      2'd0: pix = DATA_W'(x) + DATA_W'(1);
      2'd1: pix = first_pix ? '0 : ramp_q;
      2'd2: pix = (bar_idx_eff < 4'd8) ? DATA_W'(bar_color(bar_idx_eff[2:0])) : '0;
      default: pix = (x[3] ^ y[3]) ? '1 : '0;
    endcase
`ifdef CAM_PATGEN_FRAME_TAG_EN
    if (first_pix) pix = DATA_W'(frame_cnt);
`endif
  end

  // Run/drain FSM, raster counters, mode latch, frame counter and busy flag
  always_ff @(posedge cam0_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_cnt     <= '0;
      v_cnt     <= '0;
      mode_q    <= 2'd0;
      frame_cnt <= 16'd0;
      busy      <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          h_cnt  <= '0;
          v_cnt  <= '0;
          mode_q <= mode;
          if (start) state <= RUN;
        end
        RUN, DRAIN: begin
          if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
          end else begin
            h_cnt <= h_cnt + HW'(1);
          end
          if (h_cnt == '0 && v_cnt == '0) mode_q <= mode;
          if (frame_end) frame_cnt <= frame_cnt + 16'd1;
          if (state == RUN) begin
            if (!start) state <= DRAIN;
          end else begin
            if (start)          state <= RUN;
            else if (frame_end) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered pixel output plus frame-ramp and colour-bar trackers
  always_ff @(posedge cam0_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      ramp_q      <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= 4'd0;
    end else begin
      wr_en       <= pix_act;
      wr_data     <= pix_act ? pix : '0;
      frame_start <= pix_act && first_pix;
      if (pix_act) begin
        ramp_q <= first_pix ? DATA_W'(1) : ramp_q + DATA_W'(1);
        if (bar_cnt_eff == BCW'(BW - 1)) begin
          bar_cnt_q <= '0;
          bar_idx_q <= (bar_idx_eff < 4'd8) ? bar_idx_eff + 4'd1 : bar_idx_eff;
        end else begin
          bar_cnt_q <= bar_cnt_eff + BCW'(1);
          bar_idx_q <= bar_idx_eff;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Testbench for cam_pattern_gen with a reduced raster (40x12 total, 20x8 active).
// Honours CAM_PATGEN_FRAME_TAG_EN when it is defined for the build.
module tb_cam_pattern_gen;

  localparam int HT    = 40;
  localparam int VT    = 12;
  localparam int HS    = 1;
  localparam int HA    = 20;
  localparam int VS    = 1;
  localparam int VA    = 8;
  localparam int DW    = 16;
  localparam int FRAME = HT * VT;
  localparam int BEATS = HA * VA;

  logic          cam0_pclk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          frame_start;
  logic          busy;
  logic [15:0]   frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] beat_d[$];
  int          beat_off[$];
  int          extra_fs;

  cam_pattern_gen #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .H_ACTIVE(HA),
    .V_START(VS), .V_ACTIVE(VA), .DATA_W(DW)
  ) dut (
    .cam0_pclk  (cam0_pclk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .frame_start(frame_start),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 cam0_pclk = ~cam0_pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cam0_pclk);
    #1;
  endtask

  function automatic logic [15:0] bar_ref(input int b);
    case (b)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected value of beat k of a frame; fidx = frames completed before this one
  function automatic logic [15:0] exp_pix(input logic [1:0] m, input int k, input int fidx);
    int x;
    int y;
    x = k % HA;
    y = k / HA;
`ifdef CAM_PATGEN_FRAME_TAG_EN
    if (k == 0) return 16'(fidx);
`else
    if (fidx < 0) return 16'h0;
`endif
    case (m)
      2'd0: return 16'(x + 1);
      2'd1: return 16'(k);
      2'd2: return (x < 8 * (HA / 8)) ? bar_ref(x / (HA / 8)) : 16'h0000;
      default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Record one frame period starting at its frame_start; new_mode is applied mid-frame
  task automatic capture_frame(input bit at_fs, input logic [1:0] new_mode);
    int waited;
    beat_d.delete();
    beat_off.delete();
    extra_fs = 0;
    if (!at_fs) begin
      tick();
      waited = 1;
      while (frame_start !== 1'b1 && waited < 2 * FRAME) begin
        tick();
        waited++;
      end
      chk("fs_seen", {31'd0, frame_start}, 32'd1);
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      if (i == FRAME / 2) mode = new_mode;
      if (wr_en === 1'b1) begin
        beat_d.push_back(wr_data);
        beat_off.push_back(i);
      end
      if (i > 0 && frame_start !== 1'b0) extra_fs++;
    end
  endtask

  task automatic check_frame(input string nm, input logic [1:0] m, input int fidx);
    chk({nm, "_beats"}, beat_d.size(), BEATS);
    chk({nm, "_extra_fs"}, extra_fs, 0);
    for (int k = 0; k < beat_d.size() && k < BEATS; k++) begin
      chk($sformatf("%s_data%0d", nm, k), {16'd0, beat_d[k]}, {16'd0, exp_pix(m, k, fidx)});
      chk($sformatf("%s_pos%0d", nm, k), beat_off[k], (k / HA) * HT + (k % HA));
    end
  endtask

  initial begin
    int c;
    int idle_beats;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    #100;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_wr_en", {31'd0, wr_en}, 32'd0);

    // Start: busy lags one edge, first beat after one line plus two cycles
    start = 1'b1;
    tick();
    chk("busy_lag", {31'd0, busy}, 32'd0);
    c = 0;
    while (wr_en !== 1'b1 && c < 200) begin
      tick();
      c++;
      if (c == 1) chk("busy_rise", {31'd0, busy}, 32'd1);
    end
    chk("first_beat_lat", c, HT + 2);
    chk("first_fs", {31'd0, frame_start}, 32'd1);
    chk("first_data", {16'd0, wr_data}, {16'd0, exp_pix(2'd0, 0, 0)});

    // Frame A mode 0; mode goes to 1 mid-frame and must not affect A
    capture_frame(1'b1, 2'd1);
    check_frame("A_m0", 2'd0, 0);
    chk("fcnt_A", {16'd0, frame_cnt}, 32'd1);

    capture_frame(1'b0, 2'd1);
    check_frame("B_m1", 2'd1, 1);
    chk("fcnt_B", {16'd0, frame_cnt}, 32'd2);

    // Frame C: ramp restarts at 0; change to bars for the next frame
    capture_frame(1'b0, 2'd2);
    check_frame("C_m1", 2'd1, 2);

    capture_frame(1'b0, 2'd3);
    check_frame("D_m2", 2'd2, 3);

    capture_frame(1'b0, 2'd3);
    check_frame("E_m3", 2'd3, 4);

    // Drop start early in frame F: frame completes, then generator idles
    start = 1'b0;
    capture_frame(1'b0, 2'd0);
    check_frame("F_drain", 2'd3, 5);
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("fcnt_F", {16'd0, frame_cnt}, 32'd6);
    idle_beats = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_en !== 1'b0) idle_beats++;
    end
    chk("post_drain_beats", idle_beats, 0);

    // Mid-frame asynchronous reset clears outputs immediately
    mode  = 2'd0;
    start = 1'b1;
    c = 0;
    while (wr_en !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    chk("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
    start = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("mid_rst_fs", {31'd0, frame_start}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    #20;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_wr_en", {31'd0, wr_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
